// File: rtl/pipe_scroller_pkg.sv
// Shared widths, FSM state encoding and the per-pipe scroll/respawn rule
// for the pipe-field manager.
package pipe_pkg;

    localparam int X_W = 11;
    localparam int Y_W = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        UPD  = 2'd2,
        HOLD = 2'd3
    } state_e;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] gap;
        logic           wrap;
        logic           score;
    } step_t;

    // A pipe at or left of SPEED wraps three spacings to the right and takes a new gap.
    function automatic step_t pipe_step(
        input logic [X_W-1:0] x,
        input logic [Y_W-1:0] gap,
        input logic [7:0]     rnd,
        input logic [X_W-1:0] speed,
        input logic [X_W-1:0] span3,
        input logic [Y_W-1:0] gap_min,
        input logic [X_W-1:0] bird
    );
        step_t s;
        s.wrap = (x <= speed);
        if (s.wrap) begin
            s.x   = x + span3 - speed;
            s.gap = gap_min + {1'b0, rnd};
        end else begin
            s.x   = x - speed;
            s.gap = gap;
        end
        s.score = !s.wrap && (x >= bird) && (s.x < bird);
        return s;
    endfunction

endpackage

// File: rtl/pipe_scroller_if.sv
// Bundle between the game controller / LFSR (master) and the pipe field (slave).
interface pipe_scroller_if;
    import pipe_pkg::*;

    logic           tick;
    logic           start;
    logic           halt;
    logic [8:0]     P_y;
    logic [X_W-1:0] pipe_x0;
    logic [X_W-1:0] pipe_x1;
    logic [X_W-1:0] pipe_x2;
    logic [Y_W-1:0] gap_y0;
    logic [Y_W-1:0] gap_y1;
    logic [Y_W-1:0] gap_y2;
    logic           score_inc;
    logic           busy;
    logic           frame_done;

    modport master (
        output tick, start, halt, P_y,
        input  pipe_x0, pipe_x1, pipe_x2, gap_y0, gap_y1, gap_y2,
        input  score_inc, busy, frame_done
    );

    modport slave (
        input  tick, start, halt, P_y,
        output pipe_x0, pipe_x1, pipe_x2, gap_y0, gap_y1, gap_y2,
        output score_inc, busy, frame_done
    );

endinterface

// File: rtl/pipe_scroller.sv
// Three-pipe scrolling field: one pipe stepped per cycle after each frame tick,
// respawning off-screen pipes on the right with an LFSR-derived gap.
module pipe_scroller
    import pipe_pkg::*;
#(
    parameter int SPEED   = 2,
    parameter int PW      = 52,
    parameter int SPACING = 220,
    parameter int START_X = 692,
    parameter int GAP_MIN = 40,
    parameter int GAP_RST = 168,
    parameter int BIRD_X  = 200
) (
    input  logic           clk,
    input  logic           rst,
    pipe_scroller_if.slave bus
);

    localparam logic [X_W-1:0] SPEED_X   = X_W'(SPEED);
    localparam logic [X_W-1:0] SPAN3_X   = X_W'(3 * SPACING);
    localparam logic [X_W-1:0] BIRD_X_X  = X_W'(BIRD_X);
    localparam logic [Y_W-1:0] GAP_MIN_Y = Y_W'(GAP_MIN);
    localparam logic [Y_W-1:0] GAP_RST_Y = Y_W'(GAP_RST);
    localparam int             PW_UNUSED = PW;

    state_e         state_q, state_d;
    logic [1:0]     idx_q, idx_d;
    logic           halt_q, halt_d;

    logic [X_W-1:0] x_q   [3];
    logic [X_W-1:0] x_d   [3];
    logic [Y_W-1:0] gap_q [3];
    logic [Y_W-1:0] gap_d [3];
    logic           score_q, score_d;
    logic           done_q, done_d;

    logic [X_W-1:0] cur_x;
    logic [Y_W-1:0] cur_gap;
    step_t          step;
    logic           load;
    logic           upd;
    logic           unused_bits;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            halt_q  <= halt_d;
        end
    end

    // A halt seen anywhere in UPD is remembered and only acted on after pipe 2.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        halt_d  = halt_q;
        unique case (state_q)
            IDLE, HOLD: begin
                if (bus.start) begin
                    state_d = RUN;
                    idx_d   = 2'd0;
                    halt_d  = 1'b0;
                end
            end
            RUN: begin
                if (bus.halt) begin
                    state_d = HOLD;
                end else if (bus.tick) begin
                    state_d = UPD;
                    idx_d   = 2'd0;
                    halt_d  = 1'b0;
                end
            end
            UPD: begin
                halt_d = halt_q | bus.halt;
                if (idx_q == 2'd2) begin
                    state_d = (halt_q | bus.halt) ? HOLD : RUN;
                    idx_d   = 2'd0;
                    halt_d  = 1'b0;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state_q == UPD);
    end

    always_comb begin
        cur_x   = x_q[0];
        cur_gap = gap_q[0];
        if (idx_q == 2'd1) begin
            cur_x   = x_q[1];
            cur_gap = gap_q[1];
        end else if (idx_q == 2'd2) begin
            cur_x   = x_q[2];
            cur_gap = gap_q[2];
        end
    end

    assign step = pipe_step(cur_x, cur_gap, bus.P_y[7:0], SPEED_X, SPAN3_X, GAP_MIN_Y, BIRD_X_X);
    assign load = ((state_q == IDLE) || (state_q == HOLD)) && bus.start;
    assign upd  = (state_q == UPD);

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            x_d[i]   = x_q[i];
            gap_d[i] = gap_q[i];
            if (load) begin
                x_d[i]   = X_W'(START_X + i * SPACING);
                gap_d[i] = GAP_RST_Y;
            end else if (upd && (idx_q == 2'(i))) begin
                x_d[i]   = step.x;
                gap_d[i] = step.gap;
            end
        end
        score_d = upd && step.score;
        done_d  = upd && (idx_q == 2'd2);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                x_q[i]   <= X_W'(START_X + i * SPACING);
                gap_q[i] <= GAP_RST_Y;
            end
            score_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                x_q[i]   <= x_d[i];
                gap_q[i] <= gap_d[i];
            end
            score_q <= score_d;
            done_q  <= done_d;
        end
    end

    assign bus.pipe_x0    = x_q[0];
    assign bus.pipe_x1    = x_q[1];
    assign bus.pipe_x2    = x_q[2];
    assign bus.gap_y0     = gap_q[0];
    assign bus.gap_y1     = gap_q[1];
    assign bus.gap_y2     = gap_q[2];
    assign bus.score_inc  = score_q;
    assign bus.frame_done = done_q;

    // P_y[8] and the wrap flag carry no meaning for the field itself.
    assign unused_bits = bus.P_y[8] ^ step.wrap ^ (PW_UNUSED == 0);

endmodule
